// File: rtl/sys_defs.sv
// Shared pipeline definitions: the fetch-to-decode packet and the sizing
// constants of the instruction queue that sits between those stages.
package sys_defs;

  localparam int IFQ_DEPTH = 8;
  localparam int IFQ_PTR_W = $clog2(IFQ_DEPTH);
  localparam int IFQ_CNT_W = IFQ_PTR_W + 1;
  localparam int IFQ_WIDTH = 3;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] NPC;
    logic [31:0] PC;
  } IF_ID_PACKET;

endpackage

// File: rtl/if_id_queue.sv
// Program-ordered circular buffer between 3-wide fetch and 3-wide decode.
// Output slot 0 always carries the oldest buffered instruction.
module if_id_queue
  import sys_defs::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   squash,
  input  IF_ID_PACKET            in_packet_0,
  input  IF_ID_PACKET            in_packet_1,
  input  IF_ID_PACKET            in_packet_2,
  input  logic [1:0]             in_count,
  output logic                   in_ready,
  output IF_ID_PACKET            out_packet_0,
  output IF_ID_PACKET            out_packet_1,
  output IF_ID_PACKET            out_packet_2,
  output logic [1:0]             out_count,
  input  logic [1:0]             deq_count,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Largest occupancy that still leaves room for a full fetch group.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - IFQ_WIDTH);

  IF_ID_PACKET      mem     [DEPTH];
  IF_ID_PACKET      in_pkt  [IFQ_WIDTH];
  IF_ID_PACKET      out_pkt [IFQ_WIDTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       enq_n;
  logic [1:0]       deq_n;
  logic             error_deq_over;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_pkt[0] = in_packet_0;
    in_pkt[1] = in_packet_1;
    in_pkt[2] = in_packet_2;

    in_ready  = (count_q <= READY_MAX);
    out_count = (count_q >= CNT_W'(IFQ_WIDTH)) ? 2'd3 : count_q[1:0];

    // Squash discards the same-cycle push; a refused push is simply dropped.
    enq_n = (in_ready && !squash) ? in_count : 2'd0;

    // Decode asking for more than is presented is clamped and flagged.
    error_deq_over = (deq_count > out_count);
    deq_n          = error_deq_over ? out_count : deq_count;

    for (int k = 0; k < IFQ_WIDTH; k++) begin
      out_pkt[k] = '0;
      if (CNT_W'(k) < count_q) out_pkt[k] = mem[head + PTR_W'(k)];
    end
  end

  assign out_packet_0 = out_pkt[0];
  assign out_packet_1 = out_pkt[1];
  assign out_packet_2 = out_pkt[2];
  assign count        = count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (squash) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PTR_W'(deq_n);
      tail    <= tail + PTR_W'(enq_n);
      count_q <= count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
    end
  end

  // NOTE: storage is not reset; stale entries are never visible because outputs are masked by count.
  always_ff @(posedge clock) begin
    for (int k = 0; k < IFQ_WIDTH; k++) begin
      if (2'(k) < enq_n) mem[tail + PTR_W'(k)] <= in_pkt[k];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model.
module tb_if_id_queue;
  import sys_defs::*;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        squash = 1'b0;
  logic [1:0]  in_count = '0;
  logic [1:0]  deq_count = '0;
  logic        in_ready;
  logic [1:0]  out_count;
  logic [3:0]  count;
  IF_ID_PACKET in_packet_0 = '0;
  IF_ID_PACKET in_packet_1 = '0;
  IF_ID_PACKET in_packet_2 = '0;
  IF_ID_PACKET out_packet_0;
  IF_ID_PACKET out_packet_1;
  IF_ID_PACKET out_packet_2;

  int          n_checks = 0;
  int          n_fail = 0;
  IF_ID_PACKET mq[$];
  logic [31:0] exp_stream = '0;
  bit          track = 1'b0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .squash      (squash),
    .in_packet_0 (in_packet_0),
    .in_packet_1 (in_packet_1),
    .in_packet_2 (in_packet_2),
    .in_count    (in_count),
    .in_ready    (in_ready),
    .out_packet_0(out_packet_0),
    .out_packet_1(out_packet_1),
    .out_packet_2(out_packet_2),
    .out_count   (out_count),
    .deq_count   (deq_count),
    .count       (count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic IF_ID_PACKET mk(input logic [31:0] pc);
    IF_ID_PACKET p;
    p.valid = 1'b1;
    p.inst  = $urandom;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    return p;
  endfunction

  function automatic IF_ID_PACKET dut_out(input int k);
    case (k)
      0:       return out_packet_0;
      1:       return out_packet_1;
      default: return out_packet_2;
    endcase
  endfunction

  task automatic check_state(input string tag);
    int          sz;
    int          oc;
    IF_ID_PACKET e;
    sz = mq.size();
    oc = (sz > 3) ? 3 : sz;
    check($sformatf("%s.count", tag), 128'(count), 128'(sz));
    check($sformatf("%s.out_count", tag), 128'(out_count), 128'(oc));
    check($sformatf("%s.in_ready", tag), 128'(in_ready), 128'((DEPTH - sz) >= 3));
    for (int k = 0; k < 3; k++) begin
      e = (k < sz) ? mq[k] : '0;
      check($sformatf("%s.slot%0d", tag, k), 128'(dut_out(k)), 128'(e));
    end
  endtask

  // One clock: drive a request, advance the model, then compare everything.
  task automatic cycle(input string tag, input bit sq, input int n, input logic [31:0] pc0,
                       input int deq, output bit acc);
    IF_ID_PACKET p[3];
    IF_ID_PACKET o;
    int          sz;
    int          oc;
    int          dn;
    bit          ready;
    for (int k = 0; k < 3; k++) p[k] = mk(pc0 + 32'(4 * k));
    in_packet_0 = p[0];
    in_packet_1 = p[1];
    in_packet_2 = p[2];
    squash      = sq;
    in_count    = 2'(n);
    deq_count   = 2'(deq);
    sz    = mq.size();
    oc    = (sz > 3) ? 3 : sz;
    ready = (DEPTH - sz) >= 3;
    dn    = (deq > oc) ? oc : deq;
    if (track && !sq) begin
      for (int k = 0; k < dn; k++) begin
        o = dut_out(k);
        check($sformatf("%s.stream", tag), 128'(o.PC), 128'(exp_stream));
        exp_stream = exp_stream + 32'd4;
      end
    end
    acc = ready && !sq && (n > 0);
    @(posedge clock);
    #1;
    if (sq) begin
      mq.delete();
    end else begin
      repeat (dn) void'(mq.pop_front());
      if (ready) for (int k = 0; k < n; k++) mq.push_back(p[k]);
    end
    squash    = 1'b0;
    in_count  = '0;
    deq_count = '0;
    check_state(tag);
  endtask

  initial begin
    bit          acc;
    int          n;
    int          d;
    int          sz;
    logic [31:0] pcn;

    // Reset, then idle
    repeat (2) @(posedge clock);
    #1;
    check_state("reset");
    #3 reset_n = 1'b1;
    repeat (5) cycle("idle", 1'b0, 0, 32'h0, 0, acc);

    // Fill and partial drain
    cycle("fill_a", 1'b0, 3, 32'h0, 0, acc);
    cycle("fill_b", 1'b0, 2, 32'hC, 0, acc);
    check("fill.count", 128'(count), 128'(5));
    check("fill.pc0", 128'(out_packet_0.PC), 128'(32'h0));
    check("fill.pc1", 128'(out_packet_1.PC), 128'(32'h4));
    check("fill.pc2", 128'(out_packet_2.PC), 128'(32'h8));
    cycle("deq2", 1'b0, 0, 32'h0, 2, acc);
    check("deq2.pc0", 128'(out_packet_0.PC), 128'(32'h8));
    check("deq2.pc1", 128'(out_packet_1.PC), 128'(32'hC));
    check("deq2.pc2", 128'(out_packet_2.PC), 128'(32'h10));
    check("deq2.out_count", 128'(out_count), 128'(3));
    cycle("drain", 1'b0, 0, 32'h0, 3, acc);

    // Full boundary: push refused even with a same-cycle dequeue
    cycle("full_a", 1'b0, 3, 32'h0, 0, acc);
    cycle("full_b", 1'b0, 3, 32'hC, 0, acc);
    check("full.count", 128'(count), 128'(6));
    check("full.in_ready", 128'(in_ready), 128'(0));
    cycle("full_push", 1'b0, 3, 32'h18, 3, acc);
    check("full_push.count", 128'(count), 128'(3));
    check("full_push.pc0", 128'(out_packet_0.PC), 128'(32'hC));
    check("full_push.pc2", 128'(out_packet_2.PC), 128'(32'h14));

    // Squash beats simultaneous push and dequeue
    cycle("sq_fill", 1'b0, 2, 32'h100, 0, acc);
    check("sq_fill.count", 128'(count), 128'(5));
    cycle("squash", 1'b1, 3, 32'h200, 2, acc);
    check("squash.count", 128'(count), 128'(0));
    check("squash.out_count", 128'(out_count), 128'(0));
    cycle("post_sq", 1'b0, 1, 32'h40, 0, acc);
    check("post_sq.pc0", 128'(out_packet_0.PC), 128'(32'h40));

    // Randomized traffic with wrap-around; dequeued PCs must step by 4
    cycle("rand_clr", 1'b1, 0, 32'h0, 0, acc);
    pcn        = 32'h1000;
    exp_stream = 32'h1000;
    track      = 1'b1;
    repeat (80) begin
      n  = $urandom_range(0, 3);
      sz = mq.size();
      d  = $urandom_range(0, (sz > 3) ? 3 : sz);
      cycle("rand", 1'b0, n, pcn, d, acc);
      if (acc) pcn = pcn + 32'(4 * n);
    end
    repeat (4) begin
      sz = mq.size();
      cycle("rand_drain", 1'b0, 0, 32'h0, (sz > 3) ? 3 : sz, acc);
    end
    track = 1'b0;
    check("rand.empty", 128'(count), 128'(0));

    // Asynchronous reset between edges
    cycle("ar_a", 1'b0, 3, 32'h500, 0, acc);
    cycle("ar_b", 1'b0, 1, 32'h50C, 0, acc);
    check("ar.count", 128'(count), 128'(4));
    #2 reset_n = 1'b0;
    #1;
    mq.delete();
    check_state("async_rst");
    check("async_rst.valid0", 128'(out_packet_0.valid), 128'(0));
    reset_n = 1'b1;

    // Over-dequeue is clamped and flagged
    cycle("over_fill", 1'b0, 1, 32'h600, 0, acc);
    check("over_fill.flag", 128'(dut.error_deq_over), 128'(0));
    deq_count = 2'd3;
    #1;
    check("over.flag", 128'(dut.error_deq_over), 128'(1));
    cycle("over", 1'b0, 0, 32'h0, 3, acc);
    check("over.count", 128'(count), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Program-ordered instruction buffer between the 3-wide fetch stage and the 3-wide decode stage. It accepts up to three IF_ID_PACKETs per cycle, already in ascending PC order, and presents the oldest three buffered packets to decode. Decode retires any prefix of 0–3 of them per cycle. It is the producer side of the decode-slot ordering contract: output slot 0 always holds the oldest instruction.

## Interface
- DEPTH, 8, queue entries; power of two, ≥ 4
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- squash  input  1  flush on mispredict/exception; discards all entries
- in_packet_0/1/2  input  IF_ID_PACKET each  fetch group, program order
- in_count  input  2  number of valid fetch slots (0–3); slots 0..in_count-1 are used
- in_ready  output  1  at least 3 free entries; fetch may push this cycle
- out_packet_0/1/2  output  IF_ID_PACKET each  oldest three entries; slot 0 oldest
- out_count  output  2  min(count, 3)
- deq_count  input  2  number of out slots consumed by decode this cycle (0–3)
- count  output  $clog2(DEPTH)+1  occupancy

## Operation
- Circular buffer with head (oldest), tail (next write) and count; pointers wrap modulo DEPTH.
- Enqueue fires when in_ready=1 and in_count≠0.
  - Writes in_packet_0..in_count-1 to tail, tail+1, tail+2.
  - Advances tail by in_count.
  - in_packet_k for k≥in_count is ignored.
- in_ready = (DEPTH − count) ≥ 3, computed from the registered count before any same-cycle dequeue (conservative).
- Pushes with in_ready=0 are dropped. Fetch must hold the group.
- Dequeue: head advances by min(deq_count, out_count). deq_count > out_count is clamped, and the assertion error_deq_over fires in simulation.
- Next count = count + enq_n − deq_n. Simultaneous enqueue and dequeue are both applied.
- out_packet_k = entry[head+k] when k < count. Otherwise all fields are zero (valid=0).
- Squash has priority over enqueue and dequeue: head=tail=count=0 at the edge, and the same-cycle push is discarded.
- No re-sorting inside the queue. Ordering is guaranteed by in-order enqueue.

## Timing
- Reset (reset_n=0, any time): head=tail=count=0, out_count=0, all out_packets zero, in_ready=1.
- Storage contents after reset are don't-care and are never exposed, because outputs are masked by count.
- Reset asserted mid-operation loses all entries immediately (asynchronous).
- Latency: a packet enqueued at edge N appears on out_packet at edge N+1. There is no combinational in→out path.
- out_*, in_ready and count are functions of registered state only. No combinational dependence on deq_count or in_count.
- Full boundary: count ≥ DEPTH−2 ⇒ in_ready=0, even if decode dequeues this cycle.
- Empty boundary: count=0 ⇒ out_count=0, and deq_count is ignored.
- Wrap-around: a group straddling index DEPTH−1→0 stays contiguous in program order.

## Structure
- IF_ID_PACKET stays in sys_defs.
- Add to the shared package:
  - IFQ_DEPTH default
  - IFQ_PTR_W = $clog2(IFQ_DEPTH)
  - IFQ_CNT_W = IFQ_PTR_W+1
- No sub-module. Pointer arithmetic and output muxing are in-line.
- Output slots may later feed decode directly, replacing a post-fetch sorter.

## Test plan
- Reset then idle:
  - in_count=0 for 5 cycles → out_count=0, count=0, in_ready=1, all out_packet.valid=0.
- Fill/drain:
  - push PC 0x0/0x4/0x8 (in_count=3), next cycle push 0xC/0x10 (in_count=2), deq_count=0 → count=5, out PCs 0x0/0x4/0x8.
  - deq_count=2 → next cycle out PCs 0x8/0xC/0x10, out_count=3.
- Full:
  - DEPTH=8: push 3+3 → count=6, in_ready=0.
  - push 0x18..0x20 with deq_count=3 the same cycle → push dropped, count=3.
- Wrap-around:
  - cycle 12 packets through DEPTH=8 with mixed 1/2/3 enqueues and dequeues → output PC stream strictly +4 monotonic, no loss or duplication.
- Squash:
  - count=5, then squash=1 together with in_count=3 and deq_count=2 → next cycle count=0, out_count=0.
  - following push of PC 0x40 → out_packet_0.PC=0x40 after one cycle.
- Async reset mid-stream:
  - drop reset_n between edges at count=4 → outputs clear before the next edge, in_ready=1.
  - deq_count=3 with count=1 → count=0, error_deq_over asserted.
